// File: rtl/resource_arbiter_if.sv
// Request/grant bundle between N requesting sequencers and the resource arbiter.
// The slave modport is the arbiter side and the master modport is the requester side.
interface resource_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;

  modport master (output req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/resource_arbiter.sv
// Round-robin tenure arbiter with a fixed two-cycle idle gap between owners.
// Define RESOURCE_ARBITER_TIMEOUT_EN to build the MAX_HOLD tenure counter and the timeout pulse.
module resource_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  resource_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0] r_last_id, w_last_id_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic           w_hold_expired;

`ifdef RESOURCE_ARBITER_TIMEOUT_EN
  logic [7:0] r_cnt, w_cnt_nxt;
  assign w_hold_expired = (r_cnt == 8'(MAX_HOLD - 1));
`else
  logic w_unused_hold;
  assign w_unused_hold  = (MAX_HOLD > 0);
  assign w_hold_expired = 1'b0;
`endif

  // Search upward from last_id+1; index arithmetic wraps because N == 2**IDW.
  always_comb begin
    w_win = r_last_id;
    w_any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!w_any && bus.req[IDW'(r_last_id + IDW'(i))]) begin
        w_win = IDW'(r_last_id + IDW'(i));
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_last_id_nxt = r_last_id;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
    w_cnt_nxt     = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt   = S_GRANT;
          w_gnt_nxt     = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_gnt_id_nxt  = w_win;
          w_last_id_nxt = w_win;
          w_busy_nxt    = 1'b1;
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
          w_cnt_nxt     = 8'd0;
`endif
        end
      end
      S_GRANT: begin
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
        w_cnt_nxt = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
`endif
        // done outranks expiry, so a simultaneous done never raises timeout.
        if (bus.done[r_gnt_id] || !bus.req[r_gnt_id]) begin
          w_state_nxt = S_GAP;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end else if (w_hold_expired) begin
          w_state_nxt   = S_GAP;
          w_gnt_nxt     = '0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_last_id <= IDW'(N - 1);
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
      r_cnt     <= 8'd0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_last_id <= w_last_id_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.gnt_id  = r_gnt_id;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;
endmodule
